bakery_server: RTL

// Server side of the bakery ticket protocol: dispenses numbered tickets to

---
 rtl/bakery_server.sv | 131 +++++++++++++
 1 files changed

// File: rtl/bakery_server.sv
// Bakery ticket server: hands out tickets and calls holders into a single critical section.
// Latency: take -> WAIT after 1 edge, -> CS one edge later if called; release -> next owner 2 edges later.
// Backpressure: none; illegal requests are dropped with a one-cycle err pulse.
module bakery_server #(
  parameter int TKMSB  = 4,
  parameter int HIPROC = 1,
  parameter int SELMSB = 1
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [SELMSB:0]   select_i,
  input  logic              take_i,
  input  logic              release_i,
  output logic [HIPROC:0]   grant_o,
  output logic              owner_vld_o,
  output logic [SELMSB:0]   owner_o,
  output logic [TKMSB:0]    serving_o,
  output logic [TKMSB:0]    next_tkt_o,
  output logic [SELMSB:0]   nwait_o,
  output logic              err_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_CS} pstate_e;

  localparam int              NPROC  = HIPROC + 1;
  localparam logic [SELMSB:0] MAXSEL = (SELMSB+1)'(HIPROC);
  localparam logic [TKMSB:0]  TK_ONE = (TKMSB+1)'(1);
  localparam logic [SELMSB:0] CNT_ONE = (SELMSB+1)'(1);

  pstate_e         state_q  [NPROC];
  pstate_e         state_d  [NPROC];
  logic [TKMSB:0]  ticket_q [NPROC];
  logic [TKMSB:0]  ticket_d [NPROC];
  logic [TKMSB:0]  next_tkt_q, next_tkt_d;
  logic [TKMSB:0]  serving_q, serving_d;
  logic            err_q, err_d;
  logic [SELMSB:0] sel;

  // Out-of-range selectors fold onto process 0.
  assign sel = (select_i > MAXSEL) ? '0 : select_i;

  // Next state: queue promotion for every process, plus the selected process's request.
  always_comb begin
    state_d    = state_q;
    ticket_d   = ticket_q;
    next_tkt_d = next_tkt_q;
    serving_d  = serving_q;
    err_d      = 1'b0;
    for (int p = 0; p < NPROC; p++) begin
      // A waiting process is called as soon as its ticket comes up, whatever is selected.
      if (state_q[p] == ST_WAIT && ticket_q[p] == serving_q) begin
        state_d[p] = ST_CS;
      end
      if (int'(sel) == p) begin
        case (state_q[p])
          ST_IDLE: begin
            if (take_i) begin
              state_d[p]  = ST_WAIT;
              ticket_d[p] = next_tkt_q;
              next_tkt_d  = next_tkt_q + TK_ONE;
            end
            // Nothing to release from IDLE, even if a take was accepted.
            if (release_i) begin
              err_d = 1'b1;
            end
          end
          ST_WAIT: begin
            if (take_i || release_i) begin
              err_d = 1'b1;
            end
          end
          ST_CS: begin
            // Release wins over a simultaneous take.
            if (release_i) begin
              state_d[p]  = ST_IDLE;
              ticket_d[p] = '0;
              serving_d   = serving_q + TK_ONE;
            end else if (take_i) begin
              err_d = 1'b1;
            end
          end
          default: begin
            state_d[p] = ST_IDLE;
          end
        endcase
      end
    end
  end

  // State, ticket and counter registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int p = 0; p < NPROC; p++) begin
        state_q[p]  <= ST_IDLE;
        ticket_q[p] <= '0;
      end
      next_tkt_q <= '0;
      serving_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ticket_q   <= ticket_d;
      next_tkt_q <= next_tkt_d;
      serving_q  <= serving_d;
      err_q      <= err_d;
    end
  end

  // Status outputs decoded purely from registered state.
  always_comb begin
    grant_o     = '0;
    owner_vld_o = 1'b0;
    owner_o     = '0;
    nwait_o     = '0;
    for (int p = 0; p < NPROC; p++) begin
      if (state_q[p] == ST_CS) begin
        grant_o[p]  = 1'b1;
        owner_vld_o = 1'b1;
        owner_o     = (SELMSB+1)'(p);
      end
      if (state_q[p] == ST_WAIT) begin
        nwait_o = nwait_o + CNT_ONE;
      end
    end
  end

  assign serving_o  = serving_q;
  assign next_tkt_o = next_tkt_q;
  assign err_o      = err_q;

endmodule
